// File: rtl/pkt_stat_arbiter_pkg.sv
// Shared definitions for the two-source packet-status arbiter: default
// geometry, source-index encoding and the drop-counter helper.
package pkt_arb_pkg;

  // Status beat: [15:0] length, [23:16] port.
  localparam int SW_DEFAULT    = 24;
  // Per-source FIFO depth in beats (power of two, at least 2).
  localparam int DEPTH_DEFAULT = 4;
  // Width of the per-source drop counters.
  localparam int DROP_CW       = 32;

  // Source index carried on axis_out_tid and kept as the round-robin pointer.
  typedef enum logic [0:0] {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [DROP_CW-1:0] sat_inc(input logic [DROP_CW-1:0] v);
    if (v == {DROP_CW{1'b1}}) begin
      return v;
    end else begin
      return v + DROP_CW'(1);
    end
  endfunction

endpackage

// File: rtl/pkt_stat_arbiter_if.sv
// Bundle of the two unstallable status sources and the AXI-Stream style
// output. The arbiter uses the slave view; the source/sink side uses master.
interface pkt_stat_arbiter_if
  import pkt_arb_pkg::*;
#(
  parameter int SW = SW_DEFAULT
);

  logic [SW-1:0] axis_in0_tdata;
  logic          axis_in0_tuser;
  logic          axis_in0_tvalid;
  logic [SW-1:0] axis_in1_tdata;
  logic          axis_in1_tuser;
  logic          axis_in1_tvalid;

  logic [SW-1:0] axis_out_tdata;
  logic          axis_out_tuser;
  logic          axis_out_tid;
  logic          axis_out_tvalid;
  logic          axis_out_tready;

  modport slave (
    input  axis_in0_tdata, axis_in0_tuser, axis_in0_tvalid,
    input  axis_in1_tdata, axis_in1_tuser, axis_in1_tvalid,
    input  axis_out_tready,
    output axis_out_tdata, axis_out_tuser, axis_out_tid, axis_out_tvalid
  );

  modport master (
    output axis_in0_tdata, axis_in0_tuser, axis_in0_tvalid,
    output axis_in1_tdata, axis_in1_tuser, axis_in1_tvalid,
    output axis_out_tready,
    input  axis_out_tdata, axis_out_tuser, axis_out_tid, axis_out_tvalid
  );

endinterface

// File: rtl/pkt_status_fifo.sv
// Small show-ahead FIFO for status beats. The head word is visible on
// rd_data_o whenever the FIFO is not empty. A write to a full FIFO is
// still taken when the same cycle pops the head, since that slot frees
// up on the same edge.
module pkt_status_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  wr_ptr_d;
  logic [AW:0]  rd_ptr_q;
  logic [AW:0]  rd_ptr_d;
  logic         do_wr_s;
  logic         do_rd_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd_s   = rd_en_i & ~empty_o;
  assign do_wr_s   = wr_en_i & (~full_o | do_rd_s);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance each pointer only when its side actually moves a beat.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO and drops anything queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless until covered by the pointers.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/pkt_stat_arbiter.sv
// Two-source status-beat arbiter. Each source feeds its own FIFO (the
// sources cannot be stalled, so beats hitting a full FIFO are counted and
// dropped). A single output register is refilled round-robin whenever it
// is empty or being consumed; there is no path from inputs to outputs that
// bypasses the FIFOs and the output register.
module pkt_stat_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int SW    = SW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  pkt_stat_arbiter_if.slave  bus,
  input  logic               drop_clear,
  output logic [DROP_CW-1:0] drop_count0,
  output logic [DROP_CW-1:0] drop_count1,
  output logic               overflow0,
  output logic               overflow1
);

  // Per-source FIFO plumbing; index 0/1 matches the source number.
  logic [1:0]   src_valid_s;
  logic [SW:0]  src_beat_s [2];
  logic [SW:0]  head_s [2];
  logic [1:0]   full_s;
  logic [1:0]   empty_s;
  logic [1:0]   rd_en_s;
  logic [1:0]   drop_s;

  // Arbitration and output stage.
  logic         load_s;
  logic         grant_vld_s;
  src_e         grant_src_s;
  logic [SW:0]  head_sel_s;

  logic         out_vld_q;
  logic         out_vld_d;
  logic [SW-1:0] out_data_q;
  logic [SW-1:0] out_data_d;
  logic         out_user_q;
  logic         out_user_d;
  src_e         out_tid_q;
  src_e         out_tid_d;
  src_e         last_grant_q;
  src_e         last_grant_d;

  // Drop accounting.
  logic [DROP_CW-1:0] cnt_q [2];
  logic [DROP_CW-1:0] cnt_d [2];
  logic [1:0]         ovf_q;
  logic [1:0]         ovf_d;

  assign src_valid_s   = {bus.axis_in1_tvalid, bus.axis_in0_tvalid};
  assign src_beat_s[0] = {bus.axis_in0_tuser, bus.axis_in0_tdata};
  assign src_beat_s[1] = {bus.axis_in1_tuser, bus.axis_in1_tdata};

  pkt_status_fifo #(
    .W     (SW + 1),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (src_valid_s[0]),
    .wr_data_i (src_beat_s[0]),
    .rd_en_i   (rd_en_s[0]),
    .rd_data_o (head_s[0]),
    .full_o    (full_s[0]),
    .empty_o   (empty_s[0])
  );

  pkt_status_fifo #(
    .W     (SW + 1),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (src_valid_s[1]),
    .wr_data_i (src_beat_s[1]),
    .rd_en_i   (rd_en_s[1]),
    .rd_data_o (head_s[1]),
    .full_o    (full_s[1]),
    .empty_o   (empty_s[1])
  );

  // The output register may take a new beat when it is empty or draining.
  assign load_s = ~out_vld_q | bus.axis_out_tready;

  // A beat is lost only if its FIFO is full and is not popped this cycle.
  assign drop_s = src_valid_s & full_s & ~rd_en_s;

  assign head_sel_s = (grant_src_s == SRC1) ? head_s[1] : head_s[0];

  // Pick a source: the lone non-empty one, or the one not served last time.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_src_s = SRC0;
    if (!empty_s[0] && !empty_s[1]) begin
      grant_vld_s = 1'b1;
      grant_src_s = (last_grant_q == SRC0) ? SRC1 : SRC0;
    end else if (!empty_s[0]) begin
      grant_vld_s = 1'b1;
      grant_src_s = SRC0;
    end else if (!empty_s[1]) begin
      grant_vld_s = 1'b1;
      grant_src_s = SRC1;
    end else begin
      grant_vld_s = 1'b0;
      grant_src_s = SRC0;
    end
  end

  // Pop the granted FIFO only when its head is moving into the output.
  always_comb begin
    rd_en_s = 2'b00;
    if (load_s && grant_vld_s) begin
      case (grant_src_s)
        SRC0:    rd_en_s = 2'b01;
        SRC1:    rd_en_s = 2'b10;
        default: rd_en_s = 2'b00;
      endcase
    end else begin
      rd_en_s = 2'b00;
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_user_d   = out_user_q;
    out_tid_d    = out_tid_q;
    last_grant_d = last_grant_q;
    if (load_s) begin
      out_vld_d = grant_vld_s;
      if (grant_vld_s) begin
        out_data_d   = head_sel_s[SW-1:0];
        out_user_d   = head_sel_s[SW];
        out_tid_d    = grant_src_s;
        last_grant_d = grant_src_s;
      end else begin
        out_data_d   = out_data_q;
        out_user_d   = out_user_q;
        out_tid_d    = out_tid_q;
        last_grant_d = last_grant_q;
      end
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Output register; last_grant resets to SRC1 so source 0 wins first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q    <= 1'b0;
      out_data_q   <= {SW{1'b0}};
      out_user_q   <= 1'b0;
      out_tid_q    <= SRC0;
      last_grant_q <= SRC1;
    end else begin
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
      out_tid_q    <= out_tid_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Drop counters and sticky flags; a clear strobe beats a same-cycle drop.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      cnt_d[s] = cnt_q[s];
      ovf_d[s] = ovf_q[s];
      if (drop_clear) begin
        cnt_d[s] = {DROP_CW{1'b0}};
        ovf_d[s] = 1'b0;
      end else if (drop_s[s]) begin
        cnt_d[s] = sat_inc(cnt_q[s]);
        ovf_d[s] = 1'b1;
      end else begin
        cnt_d[s] = cnt_q[s];
        ovf_d[s] = ovf_q[s];
      end
    end
  end

  // Drop accounting registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= {DROP_CW{1'b0}};
      end
      ovf_q <= 2'b00;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= cnt_d[s];
      end
      ovf_q <= ovf_d;
    end
  end

  assign bus.axis_out_tvalid = out_vld_q;
  assign bus.axis_out_tdata  = out_data_q;
  assign bus.axis_out_tuser  = out_user_q;
  assign bus.axis_out_tid    = out_tid_q;

  assign drop_count0 = cnt_q[0];
  assign drop_count1 = cnt_q[1];
  assign overflow0   = ovf_q[0];
  assign overflow1   = ovf_q[1];

endmodule

// File: tb/tb_pkt_stat_arbiter.sv
// Self-checking bench for pkt_stat_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pkt_stat_arbiter;
  import pkt_arb_pkg::*;

  localparam int SW    = 24;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drop_clear = 1'b0;
  logic [31:0] drop_count0;
  logic [31:0] drop_count1;
  logic        overflow0;
  logic        overflow1;

  pkt_stat_arbiter_if #(.SW(SW)) bus ();

  pkt_stat_arbiter #(.SW(SW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .drop_clear  (drop_clear),
    .drop_count0 (drop_count0),
    .drop_count1 (drop_count1),
    .overflow0   (overflow0),
    .overflow1   (overflow1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per source plus the visible output beat.
  logic [SW:0]   mq0 [$];
  logic [SW:0]   mq1 [$];
  bit            m_vld;
  logic [SW-1:0] m_data;
  bit            m_user;
  bit            m_tid;
  bit            m_last;
  logic [31:0]   m_cnt [2];
  bit            m_ovf [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_vld  = 1'b0;
    m_data = '0;
    m_user = 1'b0;
    m_tid  = 1'b0;
    m_last = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 32'd0;
      m_ovf[s] = 1'b0;
    end
  endtask

  // One rising edge of the reference: serve the output, then accept arrivals.
  task automatic model_edge();
    bit          load;
    int          pick;
    logic [SW:0] b;
    bit          drop [2];
    load = !m_vld || (bus.axis_out_tready === 1'b1);
    pick = -1;
    b = '0;
    if (load) begin
      if (mq0.size() > 0 && mq1.size() > 0) pick = m_last ? 0 : 1;
      else if (mq0.size() > 0) pick = 0;
      else if (mq1.size() > 0) pick = 1;
      if (pick == 0) b = mq0.pop_front();
      if (pick == 1) b = mq1.pop_front();
      if (pick >= 0) begin
        m_vld  = 1'b1;
        m_data = b[SW-1:0];
        m_user = b[SW];
        m_tid  = (pick == 1);
        m_last = (pick == 1);
      end else begin
        m_vld = 1'b0;
      end
    end
    drop[0] = 1'b0;
    drop[1] = 1'b0;
    if (bus.axis_in0_tvalid) begin
      if (mq0.size() < DEPTH) mq0.push_back({bus.axis_in0_tuser, bus.axis_in0_tdata});
      else drop[0] = 1'b1;
    end
    if (bus.axis_in1_tvalid) begin
      if (mq1.size() < DEPTH) mq1.push_back({bus.axis_in1_tuser, bus.axis_in1_tdata});
      else drop[1] = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      if (drop_clear) begin
        m_cnt[s] = 32'd0;
        m_ovf[s] = 1'b0;
      end else if (drop[s]) begin
        if (m_cnt[s] != 32'hFFFF_FFFF) m_cnt[s] = m_cnt[s] + 32'd1;
        m_ovf[s] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("tvalid", 64'(bus.axis_out_tvalid), 64'(m_vld));
    check_eq("tdata",  64'(bus.axis_out_tdata),  64'(m_data));
    check_eq("tuser",  64'(bus.axis_out_tuser),  64'(m_user));
    check_eq("tid",    64'(bus.axis_out_tid),    64'(m_tid));
    check_eq("drop_count0", 64'(drop_count0), 64'(m_cnt[0]));
    check_eq("drop_count1", 64'(drop_count1), 64'(m_cnt[1]));
    check_eq("overflow0",   64'(overflow0),   64'(m_ovf[0]));
    check_eq("overflow1",   64'(overflow1),   64'(m_ovf[1]));
  endtask

  // Called at a falling edge: run one clock, check on the next falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v0, input logic [SW-1:0] d0, input bit u0,
                       input bit v1, input logic [SW-1:0] d1, input bit u1,
                       input bit rdy, input bit clr);
    bus.axis_in0_tvalid = v0;
    bus.axis_in0_tdata  = d0;
    bus.axis_in0_tuser  = u0;
    bus.axis_in1_tvalid = v1;
    bus.axis_in1_tdata  = d1;
    bus.axis_in1_tuser  = u1;
    bus.axis_out_tready = rdy;
    drop_clear          = clr;
  endtask

  // Asynchronous reset asserted mid low-phase; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  logic [SW-1:0] d0;
  logic [SW-1:0] d1;
  bit            exp_tid;
  int            p0;
  int            p1;
  int            pr;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    compare_all();

    // Single beat on in0, output ready: visible one edge after capture.
    repeat (3) step();
    drive(1'b1, 24'h00_1040, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("lat_not_yet", 64'(bus.axis_out_tvalid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("lat_tvalid", 64'(bus.axis_out_tvalid), 64'd1);
    check_eq("lat_tdata",  64'(bus.axis_out_tdata),  64'h00_1040);
    check_eq("lat_tid",    64'(bus.axis_out_tid),    64'd0);
    check_eq("lat_drop0",  64'(drop_count0),         64'd0);
    step();

    // Both sources backlogged, ready held high: strict alternation from 0.
    do_reset();
    exp_tid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 7) drive(1'b1, 24'(i), 1'b0, 1'b1, 24'(24'h100 + i), 1'b1, 1'b1, 1'b0);
      else       drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      step();
      if (bus.axis_out_tvalid) begin
        check_eq("rr_tid", 64'(bus.axis_out_tid), 64'(exp_tid));
        exp_tid = ~exp_tid;
      end
    end
    check_eq("rr_drop0", 64'(drop_count0), 64'd0);
    check_eq("rr_drop1", 64'(drop_count1), 64'd0);

    // Stalled output, in1 streaming six beats: exactly one drop.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 24'(24'h2000 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    check_eq("ovf_count1", 64'(drop_count1), 64'd1);
    check_eq("ovf_flag1",  64'(overflow1),   64'd1);
    check_eq("ovf_head",   64'(bus.axis_out_tdata), 64'h00_2000);

    // Clear strobe coincident with another drop on in1: clear wins.
    drive(1'b0, '0, 1'b0, 1'b1, 24'h2FFF, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("clr_count1", 64'(drop_count1), 64'd0);
    check_eq("clr_flag1",  64'(overflow1),   64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (8) step();

    // Fill FIFO0 behind a stalled output, then stream through it at full rate.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 24'(24'h3000 + i), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 24'(24'h3100 + i), 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      step();
      check_eq("full_rw_tvalid", 64'(bus.axis_out_tvalid), 64'd1);
    end
    check_eq("full_rw_drop0", 64'(drop_count0), 64'd0);
    check_eq("full_rw_ovf0",  64'(overflow0),   64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (8) step();

    // Reset with beats queued and a beat held at the output.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 24'(24'h4000 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check_eq("prerst_tvalid", 64'(bus.axis_out_tvalid), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("postrst_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    end

    // Randomized traffic in segments with differing load and backpressure.
    for (int seg = 0; seg < 12; seg++) begin
      p0 = $urandom_range(0, 100);
      p1 = $urandom_range(0, 100);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 250; i++) begin
        d0 = 24'($urandom);
        d1 = 24'($urandom);
        drive($urandom_range(0, 99) < p0, d0, 1'($urandom),
              $urandom_range(0, 99) < p1, d1, 1'($urandom),
              $urandom_range(0, 99) < pr, $urandom_range(0, 49) == 0);
        if ($urandom_range(0, 399) == 0) do_reset();
        else step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
